// File: rtl/aha_sys_reset_sequencer.sv
// aha_sys_reset_sequencer
// Takes the registered system-reset request and runs a timed release
// sequence. Peripheral and CPU resets are asserted together. The
// peripheral reset is released first, and the CPU reset follows after a
// fixed gap. The same release sequence also runs after power-on reset.
// A request that stays high after the sequence parks the FSM in WAIT_LOW,
// so a stuck request cannot loop resets.
module aha_sys_reset_sequencer #(
  parameter int ASSERT_CYCLES = 16,
  parameter int STAGE_GAP     = 4,
  parameter int CNT_WIDTH     = 8
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       SYSRESETREQ,
  output logic       REQ_ACK,
  output logic       PERIPH_RESET,
  output logic       CPU_RESET,
  output logic       RESET_ACTIVE,
  output logic [7:0] RESET_COUNT
);

  // Counter reload values. Each phase lasts load+1 edges, because the
  // transition happens on the edge where the counter reads zero.
  localparam logic [CNT_WIDTH-1:0] ASSERT_LOAD = CNT_WIDTH'(ASSERT_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] STAGE_LOAD  = CNT_WIDTH'(STAGE_GAP - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE     = CNT_WIDTH'(1);
  localparam logic [7:0]           COUNT_MAX   = 8'hFF;

  typedef enum logic [1:0] {
    ST_ASSERT         = 2'd0,
    ST_RELEASE_PERIPH = 2'd1,
    ST_WAIT_LOW       = 2'd2,
    ST_IDLE           = 2'd3
  } state_e;

  state_e               state_q,    state_d;
  logic [CNT_WIDTH-1:0] cnt_q,      cnt_d;
  logic                 periph_q,   periph_d;
  logic                 cpu_q,      cpu_d;
  logic                 active_q,   active_d;
  logic                 ack_q,      ack_d;
  logic [7:0]           count_q,    count_d;
  // Set only when the running sequence came from a request, so the
  // power-on sequence does not count.
  logic                 req_init_q, req_init_d;

  // Next-state and next-output logic. The outputs are computed here so
  // that every port comes straight from a flop.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    periph_d   = periph_q;
    cpu_d      = cpu_q;
    ack_d      = 1'b0;
    count_d    = count_q;
    req_init_d = req_init_q;

    case (state_q)
      ST_ASSERT: begin
        periph_d = 1'b1;
        cpu_d    = 1'b1;
        if (cnt_q == '0) begin
          state_d  = ST_RELEASE_PERIPH;
          periph_d = 1'b0;
          cnt_d    = STAGE_LOAD;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end

      ST_RELEASE_PERIPH: begin
        periph_d = 1'b0;
        cpu_d    = 1'b1;
        if (cnt_q == '0) begin
          cpu_d   = 1'b0;
          // A request still high here must drop before the next one is
          // accepted.
          state_d = SYSRESETREQ ? ST_WAIT_LOW : ST_IDLE;
          if (req_init_q) begin
            if (count_q != COUNT_MAX) count_d = count_q + 8'd1;
            req_init_d = 1'b0;
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end

      ST_WAIT_LOW: begin
        periph_d = 1'b0;
        cpu_d    = 1'b0;
        if (!SYSRESETREQ) state_d = ST_IDLE;
      end

      ST_IDLE: begin
        periph_d = 1'b0;
        cpu_d    = 1'b0;
        if (SYSRESETREQ) begin
          state_d    = ST_ASSERT;
          periph_d   = 1'b1;
          cpu_d      = 1'b1;
          ack_d      = 1'b1;
          cnt_d      = ASSERT_LOAD;
          req_init_d = 1'b1;
        end
      end

      default: begin
        state_d  = ST_ASSERT;
        cnt_d    = ASSERT_LOAD;
        periph_d = 1'b1;
        cpu_d    = 1'b1;
      end
    endcase

    active_d = (state_d != ST_IDLE);
  end

  // State and output registers. Reset forces the power-on sequence start.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q    <= ST_ASSERT;
      cnt_q      <= ASSERT_LOAD;
      periph_q   <= 1'b1;
      cpu_q      <= 1'b1;
      active_q   <= 1'b1;
      ack_q      <= 1'b0;
      count_q    <= 8'd0;
      req_init_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      periph_q   <= periph_d;
      cpu_q      <= cpu_d;
      active_q   <= active_d;
      ack_q      <= ack_d;
      count_q    <= count_d;
      req_init_q <= req_init_d;
    end
  end

  assign REQ_ACK      = ack_q;
  assign PERIPH_RESET = periph_q;
  assign CPU_RESET    = cpu_q;
  assign RESET_ACTIVE = active_q;
  assign RESET_COUNT  = count_q;

endmodule

// File: tb/tb_aha_sys_reset_sequencer.sv
// Bench for aha_sys_reset_sequencer. The reference model tracks the
// elapsed edges since a sequence started. It derives the expected outputs
// from the timing rules, not from a counter or state encoding.
module tb_aha_sys_reset_sequencer;
  localparam int A = 16;
  localparam int G = 4;

  logic       CLK;
  logic       RESET;
  logic       SYSRESETREQ;
  logic       REQ_ACK;
  logic       PERIPH_RESET;
  logic       CPU_RESET;
  logic       RESET_ACTIVE;
  logic [7:0] RESET_COUNT;

  aha_sys_reset_sequencer #(
    .ASSERT_CYCLES(A),
    .STAGE_GAP(G),
    .CNT_WIDTH(8)
  ) dut (
    .CLK(CLK),
    .RESET(RESET),
    .SYSRESETREQ(SYSRESETREQ),
    .REQ_ACK(REQ_ACK),
    .PERIPH_RESET(PERIPH_RESET),
    .CPU_RESET(CPU_RESET),
    .RESET_ACTIVE(RESET_ACTIVE),
    .RESET_COUNT(RESET_COUNT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: a sequence is "busy" for A+G edges from its start.
  // The peripheral reset is high for the first A of those edges.
  bit m_busy;
  int m_t;
  bit m_init;
  bit m_wait;
  int m_cnt;
  bit m_ack;

  function automatic void model_reset();
    m_busy = 1; m_t = 0; m_init = 0; m_wait = 0; m_cnt = 0; m_ack = 0;
  endfunction

  function automatic void model_edge(input bit r);
    m_ack = 0;
    if (m_busy) begin
      m_t++;
      if (m_t == A + G) begin
        m_busy = 0;
        if (m_init && m_cnt < 255) m_cnt++;
        m_init = 0;
        m_wait = r;
      end
    end else if (m_wait) begin
      if (!r) m_wait = 0;
    end else if (r) begin
      m_busy = 1; m_t = 0; m_ack = 1; m_init = 1;
    end
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("ack",    {7'd0, REQ_ACK},      {7'd0, m_ack});
    chk("periph", {7'd0, PERIPH_RESET}, {7'd0, (m_busy && m_t < A)});
    chk("cpu",    {7'd0, CPU_RESET},    {7'd0, m_busy});
    chk("active", {7'd0, RESET_ACTIVE}, {7'd0, (m_busy || m_wait)});
    chk("count",  RESET_COUNT,          8'(m_cnt));
  endtask

  // One clock edge with the given request level; outputs are sampled on
  // the following falling edge.
  task automatic step(input bit r);
    SYSRESETREQ = r;
    @(posedge CLK);
    model_edge(r);
    @(negedge CLK);
    check_all();
  endtask

  // Power-on release timing, counted from the first edge after reset drops.
  task automatic por_seq(input string tag);
    for (int i = 1; i <= A + G + 2; i++) begin
      step(1'b0);
      if (i == A - 1)   chk({tag, "_p_hi"}, {7'd0, PERIPH_RESET}, 8'd1);
      if (i == A)       chk({tag, "_p_lo"}, {7'd0, PERIPH_RESET}, 8'd0);
      if (i == A+G-1)   chk({tag, "_c_hi"}, {7'd0, CPU_RESET},    8'd1);
      if (i == A+G)     chk({tag, "_c_lo"}, {7'd0, CPU_RESET},    8'd0);
      if (i == A+G)     chk({tag, "_act"},  {7'd0, RESET_ACTIVE}, 8'd0);
      chk({tag, "_noack"}, {7'd0, REQ_ACK}, 8'd0);
    end
    chk({tag, "_cnt"}, RESET_COUNT, 8'd0);
  endtask

  task automatic pulse_reset();
    #1 RESET = 1'b1;
    #1;
    chk("arst_periph", {7'd0, PERIPH_RESET}, 8'd1);
    chk("arst_cpu",    {7'd0, CPU_RESET},    8'd1);
    chk("arst_cnt",    RESET_COUNT,          8'd0);
    model_reset();
    check_all();
    @(negedge CLK);
    RESET = 1'b0;
  endtask

  initial begin
    RESET = 1'b1;
    SYSRESETREQ = 1'b0;
    model_reset();
    repeat (3) @(negedge CLK);
    chk("rst_periph", {7'd0, PERIPH_RESET}, 8'd1);
    chk("rst_cpu",    {7'd0, CPU_RESET},    8'd1);
    chk("rst_active", {7'd0, RESET_ACTIVE}, 8'd1);
    chk("rst_ack",    {7'd0, REQ_ACK},      8'd0);
    chk("rst_cnt",    RESET_COUNT,          8'd0);
    RESET = 1'b0;

    // Power-on sequence.
    por_seq("por");

    // One-cycle request.
    step(1'b1);
    chk("req_ack", {7'd0, REQ_ACK}, 8'd1);
    for (int i = 1; i <= A + G + 1; i++) begin
      step(1'b0);
      if (i == 1)     chk("req_ack_1cyc", {7'd0, REQ_ACK},      8'd0);
      if (i == A - 1) chk("req_p_hi",     {7'd0, PERIPH_RESET}, 8'd1);
      if (i == A)     chk("req_p_lo",     {7'd0, PERIPH_RESET}, 8'd0);
      if (i == A+G-1) chk("req_c_hi",     {7'd0, CPU_RESET},    8'd1);
      if (i == A+G)   chk("req_c_lo",     {7'd0, CPU_RESET},    8'd0);
      if (i == A+G)   chk("req_cnt",      RESET_COUNT,          8'd1);
    end

    // Request held high through the sequence parks the FSM in WAIT_LOW.
    step(1'b1);
    for (int i = 1; i <= A + G + 5; i++) begin
      step(1'b1);
      if (i == A)       chk("hold_p_lo", {7'd0, PERIPH_RESET}, 8'd0);
      if (i == A+G)     chk("hold_c_lo", {7'd0, CPU_RESET},    8'd0);
      if (i == A+G+5)   chk("hold_act",  {7'd0, RESET_ACTIVE}, 8'd1);
      if (i >= 1)       chk("hold_noack",{7'd0, REQ_ACK},      8'd0);
    end
    step(1'b0);
    chk("drop_idle", {7'd0, RESET_ACTIVE}, 8'd0);
    step(1'b1);
    chk("retrig_ack", {7'd0, REQ_ACK}, 8'd1);
    repeat (A + G + 1) step(1'b0);

    // Second pulse during ASSERT is absorbed.
    step(1'b1);
    for (int i = 1; i <= A + G + 1; i++) begin
      step(i == 5);
      chk("abs_noack", {7'd0, REQ_ACK}, 8'd0);
      if (i == A - 1) chk("abs_p_hi", {7'd0, PERIPH_RESET}, 8'd1);
      if (i == A)     chk("abs_p_lo", {7'd0, PERIPH_RESET}, 8'd0);
      if (i == A+G-1) chk("abs_c_hi", {7'd0, CPU_RESET},    8'd1);
      if (i == A+G)   chk("abs_c_lo", {7'd0, CPU_RESET},    8'd0);
    end

    // Asynchronous reset in RELEASE_PERIPH, then a full power-on sequence.
    step(1'b1);
    for (int i = 1; i <= 18; i++) step(1'b0);
    chk("pre_arst_cnt", RESET_COUNT, 8'd4);
    pulse_reset();
    por_seq("por2");

    // Randomized request traffic with occasional asynchronous resets.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 199) == 0) pulse_reset();
      else step($urandom_range(0, 3) == 0);
    end

    // Saturation of the completion counter.
    repeat (A + G + 4) step(1'b0);
    for (int s = 0; s < 300; s++) begin
      step(1'b1);
      repeat (A + G) step(1'b0);
    end
    chk("sat_255", RESET_COUNT, 8'd255);
    step(1'b1);
    repeat (A + G + 2) step(1'b0);
    chk("sat_hold", RESET_COUNT, 8'd255);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
